bus_bridge_master_ctrl: RTL and testbench

Far-side controller of the UART bus bridge. Consumes 32-bit request frames from the remote bridge's UART receiver, buffers them in a small FIFO, replays each as a single write or read on the local bus through a master-port request interface, and returns read data as a 16-bit UART response frame. Writes produce no response.

---
 rtl/bus_bridge_pkg.sv | 27 ++
 rtl/bridge_frame_fifo.sv | 41 ++++
 rtl/bus_bridge_master_ctrl.sv | 127 ++++++++++++
 tb/tb_bus_bridge_master_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared constants for the UART bus bridge: frame field layout, response width
// and the far-side controller's state encoding.
package bus_bridge_pkg;

    localparam int FRAME_W        = 32;
    localparam int RESP_W         = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_e;

    // Two reserved bits sit between the address and the write data.
    function automatic int wdata_lsb(input int aw);
        return aw + 2;
    endfunction

    function automatic int mode_bit(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

endpackage

// File: rtl/bridge_frame_fifo.sv
// Request frame buffer: DEPTH x WIDTH synchronous FIFO with wrap-bit pointers.
module bridge_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/bus_bridge_master_ctrl.sv
// Far-side bridge controller: buffers request frames, replays them one at a
// time on the local master port and returns read data as a UART response.
module bus_bridge_master_ctrl
    import bus_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_ready,
    input  logic [31:0]           rx_data,
    input  logic                  tx_busy,
    output logic                  tx_en,
    output logic [15:0]           tx_data,
    output logic                  m_req,
    output logic                  m_wen,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_done,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy,
    output logic                  overflow
);

    localparam int WD_LSB   = wdata_lsb(ADDR_WIDTH);
    localparam int MODE_BIT = mode_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q;
    logic                  m_wen_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [DATA_WIDTH-1:0] m_wdata_q;
    logic [RESP_W-1:0]     tx_data_q;
    logic                  busy_q, busy_d;
    logic                  ovf_q;

    logic [FRAME_W-1:0]    head;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_cnt, fifo_cnt_d;
    logic                  push, pop, to_idle;
    logic                  unused_rsvd;

    bridge_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rx_data),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // A full FIFO still takes a frame when the head leaves in the same cycle.
    assign pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign push = rx_ready && (!fifo_full || pop);

    assign to_idle = ((state_q == ST_IDLE) && fifo_empty) ||
                     ((state_q == ST_WAIT) && m_done && m_wen_q) ||
                      (state_q == ST_HOLD);
    assign fifo_cnt_d = fifo_cnt + CW'(push) - CW'(pop);
    assign busy_d     = !to_idle || (fifo_cnt_d != '0);

    // Reserved frame bits are carried through the FIFO but never inspected.
    assign unused_rsvd = ^head;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            m_wen_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (rx_ready && !push) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        m_addr_q  <= head[ADDR_WIDTH-1:0];
                        m_wdata_q <= head[WD_LSB +: DATA_WIDTH];
                        m_wen_q   <= head[MODE_BIT];
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ready) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        if (m_wen_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            tx_data_q <= RESP_W'(m_rdata);
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (!tx_busy) state_q <= ST_HOLD;
                end
                // The UART's busy flag lags tx_en by a cycle; wait it out here.
                ST_HOLD: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_req    = (state_q == ST_ISSUE);
    assign tx_en    = (state_q == ST_RESP) && !tx_busy;
    assign m_wen    = m_wen_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bus_bridge_master_ctrl.sv
// Bench for bus_bridge_master_ctrl: vector table, corner-case sequences and a
// randomized run checked against a transaction-level model.
module tb_bus_bridge_master_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0, rx_ready = 1'b0, tx_busy = 1'b0;
    logic        m_ready = 1'b0, m_done = 1'b0;
    logic [31:0] rx_data = '0;
    logic [7:0]  m_rdata = '0;
    logic        tx_en, m_req, m_wen, busy, overflow;
    logic [15:0] tx_data;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;

    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bus_bridge_master_ctrl dut (
        .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_done(m_done), .m_rdata(m_rdata),
        .busy(busy), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] frame;
        logic        wen;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [15:0] tx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Field decode from the frame layout, by plain arithmetic.
    function automatic logic [11:0] f_addr(input logic [31:0] f);
        return 12'(f % 32'd4096);
    endfunction
    function automatic logic [7:0] f_wdata(input logic [31:0] f);
        return 8'((f / 32'd16384) % 32'd256);
    endfunction
    function automatic logic f_wen(input logic [31:0] f);
        return ((f / 32'h400000) % 32'd2) == 32'd1;
    endfunction
    function automatic logic [31:0] mkw(input int addr, input int wd);
        return 32'h400000 + 32'(wd) * 32'd16384 + 32'(addr);
    endfunction

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; rx_ready = 1'b0; rx_data = '0; tx_busy = 1'b0;
        m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
        nxt(); nxt();
        rstn = 1'b1;
    endtask

    // Returns at the falling edge of the first cycle with m_req high.
    task automatic wait_req(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = m_req;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    // Completes every queued write, in order, with immediate acceptance.
    task automatic service(input string tag);
        while (exp_q.size() > 0) begin
            logic [31:0] f;
            wait_req({tag, "_req"});
            f = exp_q.pop_front();
            chk({tag, "_addr"}, 32'(m_addr), 32'(f_addr(f)));
            chk({tag, "_wdata"}, 32'(m_wdata), 32'(f_wdata(f)));
            chk({tag, "_wen"}, 32'(m_wen), 32'(f_wen(f)));
            nxt(); m_done = 1'b1; m_rdata = '0;
            nxt(); m_done = 1'b0;
        end
    endtask

    initial begin
        vec_t        vt[6];
        int          cnt, sent, pending, done_cd;
        bit          outst, cur_rd;
        logic [7:0]  rq[$];
        logic [31:0] f;
        logic [31:0] fp[6];

        vt[0] = '{32'h00694123, 1'b1, 12'h123, 8'hA5, 8'h00, 16'h0000};
        vt[1] = '{32'h000000FF, 1'b0, 12'h0FF, 8'h00, 8'h3C, 16'h003C};
        vt[2] = '{32'hFFD6BFFF, 1'b1, 12'hFFF, 8'h5A, 8'h00, 16'h0000};
        vt[3] = '{32'h00BFC000, 1'b0, 12'h000, 8'hFF, 8'h81, 16'h0081};
        vt[4] = '{32'h00000A5A, 1'b0, 12'hA5A, 8'h00, 8'hFF, 16'h00FF};
        vt[5] = '{32'h00400001, 1'b1, 12'h001, 8'h00, 8'h00, 16'h0000};

        // Reset values, sampled while reset is held.
        nxt(); nxt();
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 0);    chk("rst_m_wen", 32'(m_wen), 0);
        chk("rst_m_addr", 32'(m_addr), 0);  chk("rst_m_wdata", 32'(m_wdata), 0);
        chk("rst_tx_en", 32'(tx_en), 0);    chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);      chk("rst_overflow", 32'(overflow), 0);
        do_reset();

        // Single transactions: m_req in cycle 2, response one cycle after m_done.
        for (int v = 0; v < 6; v++) begin
            rx_ready = 1'b1; rx_data = vt[v].frame; m_ready = 1'b1; tx_busy = 1'b0;
            nxt(); rx_ready = 1'b0; rx_data = '0;
            @(negedge clk);
            chk($sformatf("v%0d_req_c1", v), 32'(m_req), 0);
            chk($sformatf("v%0d_busy_c1", v), 32'(busy), 1);
            nxt(); @(negedge clk);
            chk($sformatf("v%0d_req_c2", v), 32'(m_req), 1);
            chk($sformatf("v%0d_wen", v), 32'(m_wen), 32'(vt[v].wen));
            chk($sformatf("v%0d_addr", v), 32'(m_addr), 32'(vt[v].addr));
            chk($sformatf("v%0d_wdata", v), 32'(m_wdata), 32'(vt[v].wdata));
            nxt(); m_done = 1'b1; m_rdata = vt[v].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req_wait", v), 32'(m_req), 0);
            nxt(); m_done = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_tx_en", v), 32'(tx_en), 32'(!vt[v].wen));
            if (!vt[v].wen) chk($sformatf("v%0d_tx_data", v), 32'(tx_data), 32'(vt[v].tx));
            nxt(); @(negedge clk);
            chk($sformatf("v%0d_tx_en_after", v), 32'(tx_en), 0);
            nxt(); @(negedge clk);
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 0);
            nxt();
        end

        // TX back-pressure: tx_busy high for 20 cycles from the read completion.
        do_reset();
        rx_ready = 1'b1; rx_data = 32'h00000055; m_ready = 1'b1;
        nxt(); rx_ready = 1'b0;
        wait_req("bp_req");
        nxt(); m_done = 1'b1; m_rdata = 8'hC3; tx_busy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); cnt += int'(tx_en);
            nxt(); m_done = 1'b0;
        end
        tx_busy = 1'b0;
        @(negedge clk);
        chk("bp_tx_first_free", 32'(tx_en), 1);
        chk("bp_tx_data", 32'(tx_data), 32'h00C3);
        cnt += int'(tx_en);
        for (int i = 0; i < 8; i++) begin
            nxt(); tx_busy = (i < 3);
            @(negedge clk); cnt += int'(tx_en);
        end
        chk("bp_tx_count", 32'(cnt), 1);
        nxt();

        // Overflow: six back-to-back frames while the port is stalled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rx_ready = 1'b1; rx_data = mkw(12'h100 + i, 8'h10 + i);
            if (i < 5) exp_q.push_back(rx_data);
            nxt();
        end
        rx_ready = 1'b0;
        @(negedge clk);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_held_req", 32'(m_req), 1);
        chk("ovf_held_addr", 32'(m_addr), 32'h100);
        nxt(); m_ready = 1'b1;
        service("ovf");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); cnt += int'(m_req);
        end
        chk("ovf_no_6th", 32'(cnt), 0);
        chk("ovf_busy_end", 32'(busy), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        nxt();

        // Full FIFO plus a frame arriving in the IDLE pop cycle.
        do_reset();
        for (int i = 0; i < 6; i++) fp[i] = mkw(12'h200 + i, 8'h40 + i);
        for (int i = 1; i < 6; i++) exp_q.push_back(fp[i]);
        m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rx_ready = (c != 5); rx_data = fp[(c < 5) ? c : 5]; m_done = (c == 5);
            @(negedge clk);
            if (c == 2) chk("fp_f0_addr", 32'(m_addr), 32'h200);
            nxt();
        end
        rx_ready = 1'b0; m_done = 1'b0;
        service("fp");
        chk("fp_no_overflow", 32'(overflow), 0);
        nxt();

        // Reset during a read's WAIT with two frames queued.
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rx_ready = (c < 3);
            rx_data = (c == 0) ? 32'h000000AA : mkw(12'h300 + c, 8'h60 + c);
            nxt();
        end
        rstn = 1'b0; rx_ready = 1'b1; rx_data = mkw(12'h3FF, 8'h77);
        nxt();
        rstn = 1'b1; rx_ready = 1'b0; m_done = 1'b1; m_rdata = 8'h77;
        @(negedge clk);
        chk("mr_m_req", 32'(m_req), 0);    chk("mr_m_wen", 32'(m_wen), 0);
        chk("mr_m_addr", 32'(m_addr), 0);  chk("mr_m_wdata", 32'(m_wdata), 0);
        chk("mr_tx_en", 32'(tx_en), 0);    chk("mr_tx_data", 32'(tx_data), 0);
        chk("mr_busy", 32'(busy), 0);      chk("mr_overflow", 32'(overflow), 0);
        nxt(); m_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); cnt += int'(m_req) + int'(tx_en);
        end
        chk("mr_quiet", 32'(cnt), 0);
        nxt();

        // Randomized traffic against an in-order transaction model.
        do_reset();
        sent = 0; pending = 0; done_cd = 0; outst = 1'b0; cur_rd = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rx_ready = (sent < 60 && pending < 4 && $urandom_range(0, 2) == 0);
            rx_data  = rx_ready ? $urandom : 32'd0;
            if (rx_ready) begin exp_q.push_back(rx_data); sent++; pending++; end
            m_ready = ($urandom_range(0, 1) == 1);
            tx_busy = ($urandom_range(0, 3) == 0);
            m_done  = 1'b0;
            m_rdata = 8'($urandom);
            if (outst) begin
                if (done_cd == 0) begin
                    m_done = 1'b1; outst = 1'b0;
                    if (cur_rd) rq.push_back(m_rdata);
                end else done_cd--;
            end else if ($urandom_range(0, 7) == 0) m_done = 1'b1;
            @(negedge clk);
            if (tx_en) begin
                chk("rnd_tx_while_busy", 32'(tx_busy), 0);
                if (rq.size() == 0) chk("rnd_tx_unexpected", 32'(tx_en), 0);
                else chk("rnd_tx_data", 32'(tx_data), 32'(rq.pop_front()));
            end
            if (m_req) begin
                chk("rnd_req_overlap", 32'(outst), 0);
                if (m_ready) begin
                    if (exp_q.size() == 0) chk("rnd_req_unexpected", 32'(m_req), 0);
                    else begin
                        f = exp_q.pop_front();
                        chk("rnd_addr", 32'(m_addr), 32'(f_addr(f)));
                        chk("rnd_wdata", 32'(m_wdata), 32'(f_wdata(f)));
                        chk("rnd_wen", 32'(m_wen), 32'(f_wen(f)));
                        outst = 1'b1; cur_rd = !f_wen(f);
                        done_cd = $urandom_range(0, 2); pending--;
                    end
                end
            end
            nxt();
            if (sent == 60 && exp_q.size() == 0 && !outst && rq.size() == 0) break;
        end
        rx_ready = 1'b0; m_done = 1'b0; tx_busy = 1'b0;
        chk("rnd_all_issued", 32'(exp_q.size()), 0);
        chk("rnd_all_responded", 32'(rq.size()), 0);
        chk("rnd_sent", 32'(sent), 60);
        repeat (3) nxt();
        @(negedge clk);
        chk("rnd_busy_end", 32'(busy), 0);
        chk("rnd_no_overflow", 32'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
